// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous imem and pairs returned words with their PC.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_stall counters.
module fetch_stage #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  if_valid,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_instr,
    output logic                  if_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall
`endif
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        redirect_misaligned;

    assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Re-reading the same word while held keeps imem_data stable without a capture register.
    always_comb begin
        req_pc = pc + 32'd4;
        if (redirect_valid)
            req_pc = redirect_pc;
        else if (state == BOOT || state == FAULT || stall)
            req_pc = pc;
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (redirect_misaligned) state_next = FAULT;
            FAULT:   if (redirect_valid && !redirect_misaligned) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= req_pc;
        end
    end

    assign imem_addr = req_pc[ADDR_WIDTH+1:2];
    assign if_valid  = (state == RUN) && !redirect_valid;
    assign if_pc     = pc;
    assign if_instr  = imem_data;
    assign if_fault  = (state == FAULT);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else if (if_valid) begin
            if (stall)
                perf_stall   <= perf_stall + 32'd1;
            else
                perf_fetched <= perf_fetched + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle synchronous imem model (word i = 32'h1000_0000 + i).
module tb_fetch_stage;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          stall;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          if_valid;
    logic [31:0]   if_pc;
    logic [31:0]   if_instr;
    logic          if_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_stall;
`endif

    logic [31:0] mem [0:(1<<AW)-1];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    fetch_stage #(.ADDR_WIDTH(AW), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .if_fault(if_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; return at the following negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 + i;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) step();
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_fault", {31'b0, if_fault}, 32'd0);
        check("rst_pc", if_pc, 32'h0);

        rst = 1'b0; #1;
        check("boot_addr", {22'b0, imem_addr}, 32'd0);
        check("boot_valid", {31'b0, if_valid}, 32'd0);

        for (int k = 0; k < 3; k++) begin
            step();
            check("seq_pc", if_pc, 32'(4 * k));
            check("seq_instr", if_instr, 32'h1000_0000 + 32'(k));
            check("seq_valid", {31'b0, if_valid}, 32'd1);
        end

        // if_pc=8: hold for three edges
        stall = 1'b1; #1;
        check("stall_addr", {22'b0, imem_addr}, 32'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_pc", if_pc, 32'h8);
            check("stall_instr", if_instr, 32'h1000_0002);
            check("stall_valid", {31'b0, if_valid}, 32'd1);
            check("stall_addr", {22'b0, imem_addr}, 32'd2);
        end
        stall = 1'b0;
        step();
        check("unstall_pc", if_pc, 32'hC);
        check("unstall_instr", if_instr, 32'h1000_0003);

        redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        check("redir_squash", {31'b0, if_valid}, 32'd0);
        check("redir_addr", {22'b0, imem_addr}, 32'h10);
        step();
        redirect_valid = 1'b0; #1;
        check("redir_pc", if_pc, 32'h40);
        check("redir_instr", if_instr, 32'h1000_0010);
        check("redir_valid", {31'b0, if_valid}, 32'd1);

        redirect_valid = 1'b1; redirect_pc = 32'h42; #1;
        check("mis_fault_pre", {31'b0, if_fault}, 32'd0);
        step();
        redirect_valid = 1'b0; #1;
        for (int k = 0; k < 2; k++) begin
            check("fault_flag", {31'b0, if_fault}, 32'd1);
            check("fault_valid", {31'b0, if_valid}, 32'd0);
            check("fault_pc", if_pc, 32'h42);
            check("fault_addr", {22'b0, imem_addr}, 32'h10);
            step();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h80; #1;
        check("recover_fault_pre", {31'b0, if_fault}, 32'd1);
        step();
        redirect_valid = 1'b0; #1;
        check("recover_fault", {31'b0, if_fault}, 32'd0);
        check("recover_pc", if_pc, 32'h80);
        check("recover_instr", if_instr, 32'h1000_0020);
        check("recover_valid", {31'b0, if_valid}, 32'd1);

        // redirect and stall together: redirect wins
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        check("rs_squash", {31'b0, if_valid}, 32'd0);
        step();
        redirect_valid = 1'b0; #1;
        check("rs_pc", if_pc, 32'h100);
        check("rs_instr", if_instr, 32'h1000_0040);
        check("rs_valid", {31'b0, if_valid}, 32'd1);
        stall = 1'b0;

        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        check("wrap_addr_hi", {22'b0, imem_addr}, 32'h3FF);
        step();
        redirect_valid = 1'b0; #1;
        check("wrap_pc_hi", if_pc, 32'hFFFF_FFFC);
        check("wrap_instr_hi", if_instr, 32'h1000_03FF);
        check("wrap_addr_lo", {22'b0, imem_addr}, 32'h0);
        step();
        check("wrap_pc_lo", if_pc, 32'h0);
        check("wrap_instr_lo", if_instr, 32'h1000_0000);

        redirect_valid = 1'b1; redirect_pc = 32'h6; #1;
        step();
        redirect_valid = 1'b0; #1;
        check("prerst_fault", {31'b0, if_fault}, 32'd1);
        rst = 1'b1; #1;
        check("arst_fault", {31'b0, if_fault}, 32'd0);
        check("arst_valid", {31'b0, if_valid}, 32'd0);
        check("arst_pc", if_pc, 32'h0);
        step();
        rst = 1'b0; #1;
        check("reboot_addr", {22'b0, imem_addr}, 32'd0);
        check("reboot_valid", {31'b0, if_valid}, 32'd0);

        // 10 unstalled fetches then 3 stall cycles
        for (int k = 0; k < 11; k++) begin
            step();
            check("rerun_pc", if_pc, 32'(4 * k));
            check("rerun_instr", if_instr, 32'h1000_0000 + 32'(k));
        end
        stall = 1'b1;
        repeat (3) step();
        check("perf_hold_pc", if_pc, 32'h28);
        stall = 1'b0; #1;
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'd10);
        check("perf_stall", perf_stall, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the synchronous instruction memory (1-cycle read latency, word-indexed address).
- Owns the PC and drives the memory address.
- Pairs each returned instruction with the PC it was fetched from, and presents a valid/pc/instr bundle to the decode stage.
- Handles stall (hold), redirect (branch/jump/flush) and misaligned-redirect fault.

Parameters:
- ADDR_WIDTH, 10, memory word-address width; must match the instruction memory depth (2^ADDR_WIDTH words).
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  ADDR_WIDTH  word address for the read at the next posedge; combinational = req_pc[ADDR_WIDTH+1:2].
- imem_data  in  32  instruction returned for the address sampled at the previous posedge.
- stall  in  1  downstream cannot accept; hold the current bundle.
- redirect_valid  in  1  change the fetch stream; squashes the current bundle.
- redirect_pc  in  32  target PC when redirect_valid=1.
- if_valid  out  1  bundle valid.
- if_pc  out  32  PC of if_instr.
- if_instr  out  32  instruction (= imem_data, passed through).
- if_fault  out  1  misaligned redirect was taken; fetch is halted.

Behaviour:
- State: pc reg (32b, PC whose data is on imem_data this cycle) and FSM state {BOOT, RUN, FAULT}.
- Reset (async, rst=1):
  - state=BOOT, pc=RESET_PC.
  - if_valid=0, if_fault=0, if_pc=RESET_PC.
  - if_instr follows imem_data (don't-care while if_valid=0).
- req_pc (combinational), highest priority first:
  - redirect_valid=1: redirect_pc.
  - state=BOOT: pc (i.e. RESET_PC).
  - state=FAULT: pc (re-read, frozen).
  - stall=1: pc (re-read same word so imem_data stays stable).
  - else: pc+4, modulo 2^32.
- On each posedge: pc <= req_pc.
- FSM transitions:
  - BOOT -> RUN unconditionally after one cycle; stall is ignored in BOOT.
  - RUN -> FAULT if redirect_valid=1 and redirect_pc[1:0]!=0.
  - RUN -> RUN on aligned redirect.
  - FAULT -> RUN on aligned redirect.
  - FAULT -> FAULT on misaligned redirect.
  - Otherwise the FSM holds its state.
- Outputs:
  - if_valid = (state==RUN) & ~redirect_valid; combinational squash of the wrong-path instruction.
  - if_pc = pc.
  - if_fault = (state==FAULT); registered, so it asserts 1 cycle after the misaligned redirect.
  - In FAULT, if_pc holds the misaligned target, for trap reporting.
- Latency:
  - First valid bundle one cycle after rst deasserts: cycle 0 BOOT issues RESET_PC, cycle 1 RUN presents it.
  - Redirect-to-target-valid: 1 cycle.
- Stall:
  - While stall=1 in RUN, if_pc and if_instr stay constant every cycle and if_valid stays 1.
  - The PC advances on the first edge with stall=0.
- Simultaneous redirect+stall: redirect wins; target issued, current bundle squashed.
- Address wrap: imem_addr is truncated from req_pc, so PCs beyond 2^(ADDR_WIDTH+2) alias; no error.
- PC 32'hFFFF_FFFC +4 wraps to 0.
- Reset mid-operation: immediate return to BOOT/RESET_PC; any in-flight read is discarded (if_valid=0 during rst).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched (32b) and perf_stall (32b).
  - perf_fetched increments on cycles with if_valid & ~stall.
  - perf_stall increments on cycles with if_valid & stall.
  - Both cleared by rst; both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release, memory preloaded word i = 32'h1000_0000+i, stall=0:
  - cycle 0: imem_addr=0, if_valid=0.
  - cycles 1..4: if_pc=0,4,8,C with if_instr=1000_0000..1000_0003, if_valid=1.
- Stall held 3 cycles while if_pc=8:
  - if_pc=8 and if_instr=1000_0002 for all 3 cycles, imem_addr=2.
  - Next cycle after release: if_pc=C.
- Redirect to 32'h40 while if_pc=C:
  - if_valid=0 that cycle.
  - Next cycle: if_pc=40, if_instr=1000_0010.
- Redirect to 32'h42, then hold:
  - if_fault=1 from next cycle, if_valid=0, if_pc=42.
  - Redirect to 32'h80: if_fault=0, if_pc=80 valid next cycle.
- Assert rst asynchronously mid-stream (between edges):
  - if_valid and if_fault drop to 0 immediately.
  - After release, sequence restarts at RESET_PC.
- With FETCH_PERF_CNT_EN: run 10 unstalled fetches plus 3 stall cycles -> perf_fetched=10, perf_stall=3.
